// File: rtl/iter_alu_muldiv.sv
// Multi-cycle integer ALU: single-cycle logic/shift/compare ops, iterative shift-add multiply and
// restoring divide behind valid/ready handshakes. Define ITER_ALU_FAST_MUL_EN for a one-cycle multiplier.
module iter_alu_muldiv #(
  parameter int XLEN = 64,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [XLEN-1:0] X,
  input  logic [XLEN-1:0] Y,
  input  logic [3:0]      OP,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [XLEN-1:0] OUTPUT,
  output logic            IS_EQUAL,
  output logic            BUSY
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND  = 4'd2,  OP_OR   = 4'd3,
    OP_XOR  = 4'd4,  OP_SLL  = 4'd5,  OP_SRL  = 4'd6,  OP_SRA  = 4'd7,
    OP_MUL  = 4'd8,  OP_MULH = 4'd9,  OP_DIV  = 4'd10, OP_REM  = 4'd11,
    OP_SLT  = 4'd12, OP_SLTU = 4'd13, OP_DIVU = 4'd14, OP_REMU = 4'd15
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_e;

  localparam logic [XLEN-1:0] MIN = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state, state_next;
  op_e               op_in, op_q;
  logic              accept, is_mul, is_sdiv, is_div, iter_mul, div_zero, div_ovf, last;
  logic              neg_q, neg_r;
  logic [SHW-1:0]    cnt;
  logic [XLEN-1:0]   a_mag, b_mag, opd, imm_result, iter_result;
  logic [2*XLEN-1:0] acc, mul_next, div_next, mul_prod;
  logic [XLEN:0]     mul_sum, div_sh, div_diff;
  logic              div_ge;

  assign op_in    = op_e'(OP);
  assign accept   = IN_VALID && (state == S_IDLE);
  assign is_mul   = op_in inside {OP_MUL, OP_MULH};
  assign is_sdiv  = op_in inside {OP_DIV, OP_REM};
  assign is_div   = is_sdiv || (op_in inside {OP_DIVU, OP_REMU});
  assign div_zero = (Y == '0);
  assign div_ovf  = is_sdiv && (X == MIN) && (Y == '1);
  assign last     = (cnt == SHW'(XLEN - 1));
  assign a_mag    = ((is_mul || is_sdiv) && X[XLEN-1]) ? -X : X;
  assign b_mag    = ((is_mul || is_sdiv) && Y[XLEN-1]) ? -Y : Y;

`ifdef ITER_ALU_FAST_MUL_EN
  logic signed [2*XLEN-1:0] fast_prod;
  assign fast_prod = $signed({{XLEN{X[XLEN-1]}}, X}) * $signed({{XLEN{Y[XLEN-1]}}, Y});
  assign iter_mul  = 1'b0;
`else
  assign iter_mul  = is_mul;
`endif

  // Results that are ready in the accept cycle (for iterative ops this value is overwritten later).
  always_comb begin
    imm_result = '0;
    case (op_in)
      OP_ADD:  imm_result = X + Y;
      OP_SUB:  imm_result = X - Y;
      OP_AND:  imm_result = X & Y;
      OP_OR:   imm_result = X | Y;
      OP_XOR:  imm_result = X ^ Y;
      OP_SLL:  imm_result = X << Y[SHW-1:0];
      OP_SRL:  imm_result = X >> Y[SHW-1:0];
      OP_SRA:  imm_result = $signed(X) >>> Y[SHW-1:0];
      OP_SLT:  imm_result = XLEN'($signed(X) < $signed(Y));
      OP_SLTU: imm_result = XLEN'(X < Y);
`ifdef ITER_ALU_FAST_MUL_EN
      OP_MUL:  imm_result = fast_prod[XLEN-1:0];
      OP_MULH: imm_result = fast_prod[2*XLEN-1:XLEN];
`endif
      OP_DIV, OP_DIVU: imm_result = div_zero ? '1 : MIN;
      OP_REM, OP_REMU: imm_result = div_zero ? X : '0;
      default: imm_result = '0;
    endcase
  end

  // acc holds {partial product high, multiplier} for MUL and {remainder, dividend/quotient} for DIV.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
  assign mul_next = {mul_sum, acc[XLEN-1:1]};
  assign div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_diff = div_sh - {1'b0, opd};
  assign div_ge   = ~div_diff[XLEN];
  assign div_next = {div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0], acc[XLEN-2:0], div_ge};
  assign mul_prod = neg_q ? -mul_next : mul_next;

  always_comb begin
    iter_result = '0;
    case (op_q)
      OP_MUL:          iter_result = mul_prod[XLEN-1:0];
      OP_MULH:         iter_result = mul_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU: iter_result = neg_q ? -div_next[XLEN-1:0] : div_next[XLEN-1:0];
      default:         iter_result = neg_r ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_next = state;
    IN_READY   = (state == S_IDLE);
    OUT_VALID  = (state == S_DONE);
    BUSY       = (state == S_MUL) || (state == S_DIV);
    case (state)
      S_IDLE: if (accept) begin
        if (iter_mul)                              state_next = S_MUL;
        else if (is_div && !div_zero && !div_ovf) state_next = S_DIV;
        else                                       state_next = S_DONE;
      end
      S_MUL, S_DIV: if (last) state_next = S_DONE;
      S_DONE:       if (OUT_READY) state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      OUTPUT   <= '0;
      IS_EQUAL <= 1'b0;
    end else if (accept) begin
      OUTPUT   <= imm_result;
      IS_EQUAL <= (X == Y);
    end else if ((state == S_MUL || state == S_DIV) && last) begin
      OUTPUT   <= iter_result;
    end
  end

  // NOTE: datapath registers carry no reset; every one is loaded at accept before it is consumed.
  always_ff @(posedge CLK) begin
    if (accept) begin
      op_q  <= op_in;
      cnt   <= '0;
      neg_q <= (is_mul || is_sdiv) && (X[XLEN-1] ^ Y[XLEN-1]);
      neg_r <= is_sdiv && X[XLEN-1];
      opd   <= is_mul ? a_mag : b_mag;
      acc   <= {{XLEN{1'b0}}, is_mul ? b_mag : a_mag};
    end else if (state == S_MUL) begin
      acc <= mul_next;
      cnt <= cnt + 1'b1;
    end else if (state == S_DIV) begin
      acc <= div_next;
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_iter_alu_muldiv.sv
// Directed bench for iter_alu_muldiv (XLEN=64): vector table plus backpressure and mid-op reset sequences.
module tb_iter_alu_muldiv;

  localparam int XLEN = 64;
`ifdef ITER_ALU_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = XLEN + 1;
`endif
  localparam int DIV_LAT = XLEN + 1;
  localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic            CLK = 1'b0;
  logic            RST_N, IN_VALID, OUT_READY;
  logic [XLEN-1:0] X, Y;
  logic [3:0]      OP;
  logic            IN_READY, OUT_VALID, IS_EQUAL, BUSY;
  logic [XLEN-1:0] OUTPUT;

  int total = 0;
  int bad   = 0;

  iter_alu_muldiv #(.XLEN(XLEN)) dut (
    .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .X(X), .Y(Y), .OP(OP), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OUTPUT(OUTPUT), .IS_EQUAL(IS_EQUAL), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  op;
    logic [63:0] x;
    logic [63:0] y;
    logic [63:0] exp;
    logic        exp_eq;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Entered and left at a falling edge; operands are scrambled after accept to prove they were captured.
  task automatic run_op(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y,
                        output logic [63:0] res, output logic eq, output int lat, output int busy_n);
    int n = 0;
    while (!IN_READY && n < 200) begin
      @(negedge CLK);
      n++;
    end
    if (!IN_READY) check("in_ready_timeout", 64'(IN_READY), 64'd1);
    IN_VALID = 1'b1;
    X = x;
    Y = y;
    OP = op;
    @(negedge CLK);
    IN_VALID = 1'b0;
    X = ONES;
    Y = 64'h1234;
    lat = 1;
    busy_n = 0;
    while (!OUT_VALID && lat < 200) begin
      if (BUSY) busy_n++;
      @(negedge CLK);
      lat++;
    end
    res = OUTPUT;
    eq  = IS_EQUAL;
  endtask

  initial begin
    logic [63:0] res;
    logic        eq;
    int          lat, busy_n, hits;

    vecs.push_back('{4'd0,  64'd5,  64'd5,  64'd10, 1'b1, 1});
    vecs.push_back('{4'd1,  64'd66, 64'd11, 64'd55, 1'b0, 1});
    vecs.push_back('{4'd1,  64'd0,  64'd1,  ONES,   1'b0, 1});
    vecs.push_back('{4'd2,  64'hF0F0, 64'hFF00, 64'hF000, 1'b0, 1});
    vecs.push_back('{4'd3,  64'hF0F0, 64'hFF00, 64'hFFF0, 1'b0, 1});
    vecs.push_back('{4'd4,  64'hF0F0, 64'hFF00, 64'h0FF0, 1'b0, 1});
    vecs.push_back('{4'd5,  64'd1,  64'd67, 64'd8,  1'b0, 1});
    vecs.push_back('{4'd6,  MIN,    64'd4,  64'h0800_0000_0000_0000, 1'b0, 1});
    vecs.push_back('{4'd7,  64'hFFFF_FFFF_FFFF_FFF8, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1});
    vecs.push_back('{4'd12, ONES,   64'd9,  64'd1,  1'b0, 1});
    vecs.push_back('{4'd13, ONES,   64'd9,  64'd0,  1'b0, 1});
    vecs.push_back('{4'd8,  64'd6,  64'd5,  64'd30, 1'b0, MUL_LAT});
    vecs.push_back('{4'd9,  MIN,    64'd4,  64'hFFFF_FFFF_FFFF_FFFE, 1'b0, MUL_LAT});
    vecs.push_back('{4'd8,  64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, MUL_LAT});
    vecs.push_back('{4'd9,  64'd3,  64'd5,  64'd0,  1'b0, MUL_LAT});
    vecs.push_back('{4'd10, 64'd66, 64'd11, 64'd6,  1'b0, DIV_LAT});
    vecs.push_back('{4'd11, 64'd62, 64'd3,  64'd2,  1'b0, DIV_LAT});
    vecs.push_back('{4'd10, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, DIV_LAT});
    vecs.push_back('{4'd11, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, ONES, 1'b0, DIV_LAT});
    vecs.push_back('{4'd10, 64'd7,  64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 1'b0, DIV_LAT});
    vecs.push_back('{4'd11, 64'd7,  64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 1'b0, DIV_LAT});
    vecs.push_back('{4'd14, ONES,   64'd2,  64'h7FFF_FFFF_FFFF_FFFF, 1'b0, DIV_LAT});
    vecs.push_back('{4'd15, ONES,   64'd2,  64'd1,  1'b0, DIV_LAT});
    vecs.push_back('{4'd10, 64'd9,  64'd0,  ONES,   1'b0, 1});
    vecs.push_back('{4'd11, 64'd9,  64'd0,  64'd9,  1'b0, 1});
    vecs.push_back('{4'd14, 64'd5,  64'd0,  ONES,   1'b0, 1});
    vecs.push_back('{4'd15, 64'd5,  64'd0,  64'd5,  1'b0, 1});
    vecs.push_back('{4'd10, MIN,    ONES,   MIN,    1'b0, 1});
    vecs.push_back('{4'd11, MIN,    ONES,   64'd0,  1'b0, 1});
    vecs.push_back('{4'd14, 64'd100, 64'd100, 64'd1, 1'b1, DIV_LAT});

    RST_N = 1'b0;
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    X = '0;
    Y = '0;
    OP = '0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    check("reset out_valid", 64'(OUT_VALID), 64'd0);
    check("reset in_ready",  64'(IN_READY),  64'd1);
    check("reset busy",      64'(BUSY),      64'd0);
    check("reset output",    OUTPUT,         64'd0);
    check("reset is_equal",  64'(IS_EQUAL),  64'd0);

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].x, vecs[i].y, res, eq, lat, busy_n);
      check($sformatf("v%0d op%0d result", i, vecs[i].op), res, vecs[i].exp);
      check($sformatf("v%0d op%0d is_equal", i, vecs[i].op), 64'(eq), 64'(vecs[i].exp_eq));
      check($sformatf("v%0d op%0d latency", i, vecs[i].op), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("v%0d op%0d busy_cycles", i, vecs[i].op), 64'(busy_n), 64'(vecs[i].lat - 1));
    end

    // Backpressure: result must hold while the consumer stalls; new requests are ignored.
    @(negedge CLK);
    OUT_READY = 1'b0;
    run_op(4'd0, 64'd3, 64'd4, res, eq, lat, busy_n);
    check("bp latency", 64'(lat), 64'd1);
    for (int c = 0; c < 5; c++) begin
      IN_VALID = 1'b1;
      X = 64'd100;
      Y = 64'd1;
      OP = 4'd1;
      check($sformatf("bp c%0d output", c),    OUTPUT,          64'd7);
      check($sformatf("bp c%0d out_valid", c), 64'(OUT_VALID),  64'd1);
      check($sformatf("bp c%0d in_ready", c),  64'(IN_READY),   64'd0);
      @(negedge CLK);
    end
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    @(negedge CLK);
    check("bp release out_valid", 64'(OUT_VALID), 64'd0);
    check("bp release in_ready",  64'(IN_READY),  64'd1);
    check("bp release output",    OUTPUT,         64'd7);

    // Reset in the middle of a divide: no result may ever appear.
    IN_VALID = 1'b1;
    X = 64'd100;
    Y = 64'd7;
    OP = 4'd10;
    @(negedge CLK);
    IN_VALID = 1'b0;
    repeat (19) @(negedge CLK);
    check("mid-div busy", 64'(BUSY), 64'd1);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    check("abort out_valid", 64'(OUT_VALID), 64'd0);
    check("abort in_ready",  64'(IN_READY),  64'd1);
    check("abort busy",      64'(BUSY),      64'd0);
    hits = 0;
    for (int c = 0; c < 80; c++) begin
      if (OUT_VALID) hits++;
      @(negedge CLK);
    end
    check("abort no result", 64'(hits), 64'd0);

    run_op(4'd10, 64'd100, 64'd7, res, eq, lat, busy_n);
    check("post-reset div result",  res,      64'd14);
    check("post-reset div latency", 64'(lat), 64'(DIV_LAT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
